// File: rtl/frame_reader.sv
// Frame buffer read side: scans one frame out of BRAM port B in raster order and
// streams it through a 2-entry skid FIFO with start-of-frame / end-of-line flags.
module frame_reader #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIXELS     = IMG_WIDTH * IMG_HEIGHT,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(IMG_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [XW-1:0]         x_q, x_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            tag_q, tag_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [EW-1:0]         ent0_q, ent0_d;
  logic [EW-1:0]         ent1_q, ent1_d;

  logic          pop;
  logic          push;
  logic          issue;
  logic          drain_done;
  logic [2:0]    occ;
  logic [EW-1:0] new_entry;

  // FSM, read issue and FIFO next-state
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    last_addr_d = last_addr_q;
    x_d         = x_q;
    tag_d       = tag_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    issue       = 1'b0;
    drain_done  = 1'b0;
    pop         = (cnt_q != 2'd0) && m_tready;
    push        = inflight_q;
    new_entry   = {tag_q, dob};
    // Slots already committed after this cycle's pop; issuing only below 2 keeps room for the return.
    occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          rd_cnt_d = {ADDR_WIDTH{1'b0}};
          x_d      = {XW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (occ < 3'd2) begin
          issue       = 1'b1;
          last_addr_d = rd_cnt_q;
          tag_d       = {rd_cnt_q == {ADDR_WIDTH{1'b0}}, x_q == LAST_X};
          if (x_q == LAST_X) begin
            x_d = {XW{1'b0}};
          end else begin
            x_d = x_q + XW'(1);
          end
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
          end
        end else begin
          issue = 1'b0;
        end
      end
      S_DRAIN: begin
        if ((cnt_q == 2'd0) && !inflight_q) begin
          drain_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d = issue;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};

    // Shift-register FIFO: ent0 is always the head
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = new_entry;
        end else begin
          ent1_d = new_entry;
        end
      end
      2'b01: ent0_d = ent1_q;
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_entry;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_entry;
        end
      end
      default: ent0_d = ent0_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= {ADDR_WIDTH{1'b0}};
      last_addr_q <= {ADDR_WIDTH{1'b0}};
      x_q         <= {XW{1'b0}};
      inflight_q  <= 1'b0;
      tag_q       <= 2'b00;
      cnt_q       <= 2'd0;
      ent0_q      <= {EW{1'b0}};
      ent1_q      <= {EW{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      last_addr_q <= last_addr_d;
      x_q         <= x_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
    end
  end

  assign enb      = issue;
  assign addrb    = issue ? rd_cnt_q : last_addr_q;
  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tuser  = ent0_q[EW-1];
  assign m_tlast  = ent0_q[EW-2];
  assign m_tdata  = ent0_q[DATA_WIDTH-1:0];
  assign done     = drain_done;
  assign busy     = (state_q != S_IDLE) && !drain_done;

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader on a 4x3 frame: cycle table for the first
// frame, scoreboard on every handshake, plus backpressure, random-ready and reset runs.
module tb_frame_reader;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;

  always #5 clk = ~clk;

  frame_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .enb(enb), .addrb(addrb), .dob(dob),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast)
  );

  logic [DW-1:0] ram [N];
  always @(posedge clk) if (enb) dob <= ram[addrb];

  typedef struct {
    logic start;
    logic ready;
    logic enb;
    int   addr;
    logic valid;
    int   data;
    logic user;
    logic last;
    logic busy;
    logic done;
  } vec_t;
  vec_t vec [17];

  int         n_total, n_pass;
  int         issued, popped, beats, users, lasts;
  bit         prev_stall;
  logic [9:0] held;
  logic [9:0] sb [$];

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) begin
      logic [9:0] e;
      e = {(i == 0) ? 1'b1 : 1'b0, ((i % W) == W - 1) ? 1'b1 : 1'b0, DW'(i)};
      sb.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample: scoreboard, stall stability and outstanding-read bound
  task automatic sample();
    logic [9:0] cur, e;
    @(negedge clk);
    cur = {m_tuser, m_tlast, m_tdata};
    if (enb) issued++;
    if (m_tvalid && m_tready) popped++;
    chk("outstanding_le2", int'((issued - popped) <= 2), 1);
    if (prev_stall) begin
      chk("stall_valid", int'(m_tvalid), 1);
      chk("stall_beat", int'(cur), int'(held));
    end
    if (m_tvalid && m_tready) begin
      chk("sb_avail", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat", int'(cur), int'(e));
      end
      beats++;
      users += int'(m_tuser);
      lasts += int'(m_tlast);
    end
    prev_stall = m_tvalid && !m_tready;
    held = cur;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_enb"}, int'(enb), 0);
    chk({p, "_addrb"}, int'(addrb), 0);
    chk({p, "_tvalid"}, int'(m_tvalid), 0);
    chk({p, "_tdata"}, int'(m_tdata), 0);
    chk({p, "_tuser"}, int'(m_tuser), 0);
    chk({p, "_tlast"}, int'(m_tlast), 0);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_done"}, int'(done), 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low in frame cycles 5..9
  task automatic run_frame(input int mode, input bit do_start, input int exp_done_t);
    bit seen;
    int done_t;
    seen = 1'b0; done_t = -1; beats = 0; users = 0; lasts = 0;
    if (do_start) push_frame();
    for (int t = 0; t < 300; t++) begin
      start = do_start && (t == 0);
      case (mode)
        1:       m_tready = 1'($urandom_range(0, 1));
        2:       m_tready = !(t >= 5 && t <= 9);
        default: m_tready = 1'b1;
      endcase
      sample();
      if (mode == 2 && t >= 6 && t <= 9) chk("bp_enb_off", int'(enb), 0);
      if (done) begin
        seen = 1'b1;
        done_t = t;
      end
      advance();
      if (seen) break;
    end
    start = 1'b0;
    m_tready = 1'b1;
    chk("done_seen", int'(seen), 1);
    if (exp_done_t >= 0) chk("done_cycle", done_t, exp_done_t);
    chk("frame_beats", beats, N);
    chk("frame_tuser", users, 1);
    chk("frame_tlast", lasts, H);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; issued = 0; popped = 0;
    beats = 0; users = 0; lasts = 0; prev_stall = 1'b0; held = '0;
    for (int i = 0; i < N; i++) ram[i] = DW'(i);
    rst = 1'b1; start = 1'b0; m_tready = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    sample();
    chk_zero("reset");
    advance();

    // Frame 1 cycle by cycle; extra starts at 6 and in the done cycle are ignored, start at 16 is taken
    for (int t = 0; t < 17; t++) begin
      vec[t].start = (t == 0 || t == 6 || t == 15 || t == 16);
      vec[t].ready = 1'b1;
      vec[t].enb   = (t >= 1 && t <= 12);
      vec[t].addr  = (t >= 1 && t <= 12) ? t - 1 : ((t > 12) ? N - 1 : 0);
      vec[t].valid = (t >= 3 && t <= 14);
      vec[t].data  = t - 3;
      vec[t].user  = (t == 3);
      vec[t].last  = (t >= 3 && t <= 14) && (((t - 3) % W) == W - 1);
      vec[t].busy  = (t >= 1 && t <= 14);
      vec[t].done  = (t == 15);
    end
    for (int t = 0; t < 17; t++) begin
      start = vec[t].start;
      m_tready = vec[t].ready;
      if (t == 0 || t == 16) push_frame();
      sample();
      chk("tbl_enb", int'(enb), int'(vec[t].enb));
      chk("tbl_addrb", int'(addrb), vec[t].addr);
      chk("tbl_tvalid", int'(m_tvalid), int'(vec[t].valid));
      if (vec[t].valid) begin
        chk("tbl_tdata", int'(m_tdata), vec[t].data);
        chk("tbl_tuser", int'(m_tuser), int'(vec[t].user));
        chk("tbl_tlast", int'(m_tlast), int'(vec[t].last));
      end
      chk("tbl_busy", int'(busy), int'(vec[t].busy));
      chk("tbl_done", int'(done), int'(vec[t].done));
      advance();
    end
    start = 1'b0;
    chk("f1_beats", beats, N);
    chk("f1_tuser", users, 1);
    chk("f1_tlast", lasts, H);

    run_frame(0, 1'b0, 14);
    run_frame(2, 1'b1, 20);
    for (int s = 1; s <= 5; s++) begin
      void'($urandom(s * 7919));
      run_frame(1, 1'b1, -1);
    end

    // Reset in frame cycle 7 aborts the frame
    push_frame();
    for (int t = 0; t < 8; t++) begin
      start = (t == 0);
      rst = (t == 7);
      sample();
      advance();
    end
    rst = 1'b0; start = 1'b0;
    sb.delete();
    issued = 0; popped = 0; prev_stall = 1'b0;
    sample();
    chk_zero("midrst");
    advance();
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("idle_enb", int'(enb), 0);
      chk("idle_busy", int'(busy), 0);
      advance();
    end
    run_frame(0, 1'b1, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
